// File: rtl/tap_pkg.sv
// Shared JTAG TAP definitions: IEEE 1149.1 state codes, synchroniser depth
// default and the next-state rule used by the controller FSM.
package tap_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SHIFT_DR = 4'h2,
        EXIT1_DR = 4'h1,
        PAUSE_DR = 4'h3,
        EXIT2_DR = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SHIFT_IR = 4'hA,
        EXIT1_IR = 4'h9,
        PAUSE_IR = 4'hB,
        EXIT2_IR = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    function automatic tap_state_e tap_next_state(input tap_state_e cur, input logic tms);
        tap_state_e nxt;
        case (cur)
            TLR:      nxt = tms ? TLR      : RTI;
            RTI:      nxt = tms ? SEL_DR   : RTI;
            SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
            SEL_IR:   nxt = tms ? TLR      : CAP_IR;
            CAP_DR:   nxt = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: nxt = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: nxt = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: nxt = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: nxt = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   nxt = tms ? SEL_DR   : RTI;
            CAP_IR:   nxt = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: nxt = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: nxt = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: nxt = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: nxt = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   nxt = tms ? SEL_DR   : RTI;
            default:  nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tck_edge_sync.sv
// Brings raw TCK/TMS/TDI into the internal_clk domain and turns TCK
// transitions into single-cycle rise/fall strobes.
module tck_edge_sync
    import tap_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tck_raw,
    input  logic tms_raw,
    input  logic tdi_raw,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_sync,
    output logic tdi_sync
);

    logic [STAGES-1:0] tck_sync_q, tck_sync_d;
    logic [STAGES-1:0] tms_sync_q, tms_sync_d;
    logic [STAGES-1:0] tdi_sync_q, tdi_sync_d;
    logic              tck_prev_q, tck_prev_d;

    // Shift each raw input one stage deeper; the extra flop remembers the last synchronised TCK.
    always_comb begin
        tck_sync_d = {tck_sync_q[STAGES-2:0], tck_raw};
        tms_sync_d = {tms_sync_q[STAGES-2:0], tms_raw};
        tdi_sync_d = {tdi_sync_q[STAGES-2:0], tdi_raw};
        tck_prev_d = tck_sync_q[STAGES-1];
    end

    // Synchroniser and previous-TCK registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync_q <= {STAGES{1'b0}};
            tms_sync_q <= {STAGES{1'b0}};
            tdi_sync_q <= {STAGES{1'b0}};
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= tck_sync_d;
            tms_sync_q <= tms_sync_d;
            tdi_sync_q <= tdi_sync_d;
            tck_prev_q <= tck_prev_d;
        end
    end

    // A glitch on TCK reaches the last stage as one clean pulse, so it yields at most one rise.
    assign tck_rise = tck_sync_q[STAGES-1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[STAGES-1] & tck_prev_q;
    assign tms_sync = tms_sync_q[STAGES-1];
    assign tdi_sync = tdi_sync_q[STAGES-1];

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller running on internal_clk: oversampled TCK, 16-state
// 1149.1 FSM advanced on TCK rise, TDO launched on TCK fall.
module tap_controller
    import tap_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       internal_clk,
    input  logic       reg_rst,
    input  logic       reg_tck,
    input  logic       reg_tms,
    input  logic       reg_tdi,
    input  logic       reg_tdo_from_dr,
    output logic       reg_tck_enable,
    output logic       reg_test_logic_reset,
    output logic       reg_capture_dr,
    output logic       reg_shift_dr,
    output logic       reg_update_dr,
    output logic       reg_capture_ir,
    output logic       reg_shift_ir,
    output logic       reg_update_ir,
    output logic       reg_digital_input,
    output logic       reg_tdo,
    output logic       reg_tdo_oe,
    output logic [3:0] reg_tap_state
);

    logic       tck_rise_s;
    logic       tck_fall_s;
    logic       tms_sync_s;
    logic       tdi_sync_s;
    tap_state_e state_q, state_d;
    logic       tdo_q, tdo_d;
    logic       tdo_oe_q, tdo_oe_d;

    tck_edge_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_tck_sync (
        .clk      (internal_clk),
        .rst      (reg_rst),
        .tck_raw  (reg_tck),
        .tms_raw  (reg_tms),
        .tdi_raw  (reg_tdi),
        .tck_rise (tck_rise_s),
        .tck_fall (tck_fall_s),
        .tms_sync (tms_sync_s),
        .tdi_sync (tdi_sync_s)
    );

    // Next state on TCK rise; TDO and its enable are relaunched on TCK fall.
    always_comb begin
        state_d  = state_q;
        tdo_d    = tdo_q;
        tdo_oe_d = tdo_oe_q;
        if (tck_rise_s) begin
            state_d = tap_next_state(state_q, tms_sync_s);
        end else begin
            state_d = state_q;
        end
        if (tck_fall_s) begin
            tdo_d    = reg_tdo_from_dr;
            tdo_oe_d = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
        end else begin
            tdo_d    = tdo_q;
            tdo_oe_d = tdo_oe_q;
        end
    end

    // FSM state and TDO pin registers; reset drops straight into TLR and disables TDO.
    always_ff @(posedge internal_clk or posedge reg_rst) begin
        if (reg_rst) begin
            state_q  <= TLR;
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    // Decoded from the state register so data registers act on the strobe that leaves the state.
    assign reg_test_logic_reset = (state_q == TLR);
    assign reg_capture_dr       = (state_q == CAP_DR);
    assign reg_shift_dr         = (state_q == SHIFT_DR);
    assign reg_update_dr        = (state_q == UPD_DR);
    assign reg_capture_ir       = (state_q == CAP_IR);
    assign reg_shift_ir         = (state_q == SHIFT_IR);
    assign reg_update_ir        = (state_q == UPD_IR);

    assign reg_tck_enable    = tck_rise_s;
    assign reg_digital_input = tdi_sync_s;
    assign reg_tdo           = tdo_q;
    assign reg_tdo_oe        = tdo_oe_q;
    assign reg_tap_state     = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: cycle model of synchroniser latency
// plus a table-driven 1149.1 state graph, directed scenarios and random TCK traffic.
module tb_tap_controller;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       reg_tck = 1'b0;
    logic       reg_tms = 1'b0;
    logic       reg_tdi = 1'b0;
    logic       reg_tdo_from_dr = 1'b0;
    logic       reg_tck_enable;
    logic       reg_test_logic_reset;
    logic       reg_capture_dr, reg_shift_dr, reg_update_dr;
    logic       reg_capture_ir, reg_shift_ir, reg_update_ir;
    logic       reg_digital_input;
    logic       reg_tdo;
    logic       reg_tdo_oe;
    logic [3:0] reg_tap_state;

    tap_controller #(.SYNC_STAGES(S)) dut (
        .internal_clk         (clk),
        .reg_rst              (rst),
        .reg_tck              (reg_tck),
        .reg_tms              (reg_tms),
        .reg_tdi              (reg_tdi),
        .reg_tdo_from_dr      (reg_tdo_from_dr),
        .reg_tck_enable       (reg_tck_enable),
        .reg_test_logic_reset (reg_test_logic_reset),
        .reg_capture_dr       (reg_capture_dr),
        .reg_shift_dr         (reg_shift_dr),
        .reg_update_dr        (reg_update_dr),
        .reg_capture_ir       (reg_capture_ir),
        .reg_shift_ir         (reg_shift_ir),
        .reg_update_ir        (reg_update_ir),
        .reg_digital_input    (reg_digital_input),
        .reg_tdo              (reg_tdo),
        .reg_tdo_oe           (reg_tdo_oe),
        .reg_tap_state        (reg_tap_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;
    logic di_at_strobe = 1'b0;
    logic chk_on = 1'b0;

    // State graph indexed by state code: successor for TMS=0 and TMS=1.
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    // Model: raw pin history sampled each clock; synchronised value is S samples old.
    logic [7:0] m_tck_h, m_tms_h, m_tdi_h;
    logic [3:0] m_state;
    logic       m_tdo, m_oe;
    logic       m_rise, m_fall;
    assign m_rise = m_tck_h[S-1] & ~m_tck_h[S];
    assign m_fall = ~m_tck_h[S-1] & m_tck_h[S];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tck_h <= 8'h00;
            m_tms_h <= 8'h00;
            m_tdi_h <= 8'h00;
            m_state <= 4'hF;
            m_tdo   <= 1'b0;
            m_oe    <= 1'b0;
        end else begin
            if (m_rise) m_state <= m_tms_h[S-1] ? nxt1[m_state] : nxt0[m_state];
            if (m_fall) begin
                m_tdo <= reg_tdo_from_dr;
                m_oe  <= (m_state == 4'h2) || (m_state == 4'hA);
            end
            m_tck_h <= {m_tck_h[6:0], reg_tck};
            m_tms_h <= {m_tms_h[6:0], reg_tms};
            m_tdi_h <= {m_tdi_h[6:0], reg_tdi};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("tck_enable", {31'd0, reg_tck_enable}, {31'd0, m_rise});
            chk("tap_state", {28'd0, reg_tap_state}, {28'd0, m_state});
            chk("tlr", {31'd0, reg_test_logic_reset}, {31'd0, m_state == 4'hF});
            chk("capture_dr", {31'd0, reg_capture_dr}, {31'd0, m_state == 4'h6});
            chk("shift_dr", {31'd0, reg_shift_dr}, {31'd0, m_state == 4'h2});
            chk("update_dr", {31'd0, reg_update_dr}, {31'd0, m_state == 4'h5});
            chk("capture_ir", {31'd0, reg_capture_ir}, {31'd0, m_state == 4'hE});
            chk("shift_ir", {31'd0, reg_shift_ir}, {31'd0, m_state == 4'hA});
            chk("update_ir", {31'd0, reg_update_ir}, {31'd0, m_state == 4'hD});
            chk("digital_input", {31'd0, reg_digital_input}, {31'd0, m_tdi_h[S-1]});
            chk("tdo", {31'd0, reg_tdo}, {31'd0, m_tdo});
            chk("tdo_oe", {31'd0, reg_tdo_oe}, {31'd0, m_oe});
        end
    end

    // Strobe counter and TDI captured at each strobe.
    always @(negedge clk) begin
        if (reg_tck_enable) begin
            n_strobe     <= n_strobe + 1;
            di_at_strobe <= reg_digital_input;
        end
    end

    task automatic tck_pulse(input logic tms, input logic tdi, input logic tdo_dr,
                             input int hi, input int lo);
        @(negedge clk);
        reg_tms = tms;
        reg_tdi = tdi;
        reg_tdo_from_dr = tdo_dr;
        reg_tck = 1'b1;
        repeat (hi) @(negedge clk);
        reg_tck = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic step(input logic tms, input logic [3:0] exp_state);
        tck_pulse(tms, 1'b0, 1'b0, 4, 6);
        chk("step_state", {28'd0, reg_tap_state}, {28'd0, exp_state});
    endtask

    initial begin
        int base;
        logic [3:0] ir_bits;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", {28'd0, reg_tap_state}, 32'h0000000F);
        chk("rst_tlr", {31'd0, reg_test_logic_reset}, 32'd1);
        chk("rst_enable", {31'd0, reg_tck_enable}, 32'd0);
        chk("rst_shift_dr", {31'd0, reg_shift_dr}, 32'd0);
        chk("rst_tdo_oe", {31'd0, reg_tdo_oe}, 32'd0);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Eight TCK pulses with TMS low: TLR then RTI, exactly eight strobes.
        base = n_strobe;
        step(1'b0, 4'hC);
        repeat (7) tck_pulse(1'b0, 1'b0, 1'b0, 4, 6);
        chk("strobe_count8", n_strobe - base, 32'd8);
        chk("rti_code", {28'd0, reg_tap_state}, 32'h0000000C);

        // Into SHIFT_DR; TDO follows the DR pattern 1,0,1,1 on each fall.
        step(1'b1, 4'h7);
        step(1'b0, 4'h6);
        chk("capture_dr_hi", {31'd0, reg_capture_dr}, 32'd1);
        step(1'b0, 4'h2);
        chk("capture_dr_lo", {31'd0, reg_capture_dr}, 32'd0);
        chk("oe_in_shift_dr", {31'd0, reg_tdo_oe}, 32'd1);
        tck_pulse(1'b0, 1'b0, 1'b1, 4, 6);
        chk("tdo_b0", {31'd0, reg_tdo}, 32'd1);
        tck_pulse(1'b0, 1'b0, 1'b0, 4, 6);
        chk("tdo_b1", {31'd0, reg_tdo}, 32'd0);
        tck_pulse(1'b0, 1'b0, 1'b1, 4, 6);
        chk("tdo_b2", {31'd0, reg_tdo}, 32'd1);
        tck_pulse(1'b0, 1'b0, 1'b1, 4, 6);
        chk("tdo_b3", {31'd0, reg_tdo}, 32'd1);
        chk("shift_dr_held", {31'd0, reg_shift_dr}, 32'd1);

        // Five TMS-high strobes from SHIFT_DR land in TLR.
        step(1'b1, 4'h1);
        step(1'b1, 4'h5);
        step(1'b1, 4'h7);
        step(1'b1, 4'h4);
        step(1'b1, 4'hF);
        chk("tlr_after5", {31'd0, reg_test_logic_reset}, 32'd1);

        // IR path: shift 0101 LSB first, then exit and update.
        step(1'b0, 4'hC);
        step(1'b1, 4'h7);
        step(1'b1, 4'h4);
        step(1'b0, 4'hE);
        step(1'b0, 4'hA);
        ir_bits = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tck_pulse(1'b0, ir_bits[i], 1'b0, 4, 6);
            chk("di_at_strobe", {31'd0, di_at_strobe}, {31'd0, ir_bits[i]});
        end
        step(1'b1, 4'h9);
        step(1'b1, 4'hD);
        chk("update_ir_hi", {31'd0, reg_update_ir}, 32'd1);
        step(1'b0, 4'hC);
        chk("update_ir_lo", {31'd0, reg_update_ir}, 32'd0);

        // PAUSE_IR back to TLR with five TMS-high strobes.
        step(1'b1, 4'h7);
        step(1'b1, 4'h4);
        step(1'b0, 4'hE);
        step(1'b1, 4'h9);
        step(1'b0, 4'hB);
        step(1'b1, 4'h8);
        step(1'b1, 4'hD);
        step(1'b1, 4'h7);
        step(1'b1, 4'h4);
        step(1'b1, 4'hF);

        // One-cycle TCK glitch gives exactly one strobe.
        base = n_strobe;
        @(negedge clk);
        reg_tms = 1'b1;
        reg_tck = 1'b1;
        @(negedge clk);
        reg_tck = 1'b0;
        repeat (6) @(negedge clk);
        chk("glitch_strobes", n_strobe - base, 32'd1);

        // Reset mid SHIFT_IR between clock edges.
        step(1'b0, 4'hC);
        step(1'b1, 4'h7);
        step(1'b1, 4'h4);
        step(1'b0, 4'hE);
        step(1'b0, 4'hA);
        tck_pulse(1'b0, 1'b1, 1'b1, 4, 6);
        chk("oe_in_shift_ir", {31'd0, reg_tdo_oe}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", {28'd0, reg_tap_state}, 32'h0000000F);
        chk("async_rst_shift_ir", {31'd0, reg_shift_ir}, 32'd0);
        chk("async_rst_oe", {31'd0, reg_tdo_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        step(1'b0, 4'hC);

        // Random TCK traffic with occasional glitches and resets.
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                @(posedge clk);
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 7) begin
                @(negedge clk);
                reg_tms = 1'($urandom);
                reg_tck = 1'b1;
                @(negedge clk);
                reg_tck = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                tck_pulse(1'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
            end
        end

        repeat (8) @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on reg_tck/reg_tms/reg_tdi (legal values 2..4).
REQ-002 internal_clk  in  1  system clock; all state and flops are clocked on its rising edge.
REQ-003 reg_rst  in  1  reset, asynchronous and active-high.
REQ-004 reg_tck  in  1  raw JTAG TCK; asynchronous to internal_clk, at most internal_clk/4.
REQ-005 reg_tms  in  1  raw JTAG TMS.
REQ-006 reg_tdi  in  1  raw JTAG TDI.
REQ-007 reg_tdo_from_dr  in  1  serial output of the data/instruction register mux.
REQ-008 reg_tck_enable  out  1  one-cycle strobe, synchronised TCK rising edge.
REQ-009 reg_test_logic_reset  out  1  high while the FSM is in TEST_LOGIC_RESET.
REQ-010 reg_capture_dr, reg_shift_dr, reg_update_dr  out  1 each  high while the FSM is in CAPTURE_DR / SHIFT_DR / UPDATE_DR.
REQ-011 reg_capture_ir, reg_shift_ir, reg_update_ir  out  1 each  high while the FSM is in CAPTURE_IR / SHIFT_IR / UPDATE_IR.
REQ-012 reg_digital_input  out  1  synchronised TDI, aligned with reg_tck_enable.
REQ-013 reg_tdo  out  1  registered TDO pin value.
REQ-014 reg_tdo_oe  out  1  TDO output enable.
REQ-015 reg_tap_state  out  4  current FSM state code, for debug.

Function
REQ-016 TCK, TMS and TDI SHALL each pass through SYNC_STAGES flops, and one further flop SHALL hold the previous synchronised TCK.
REQ-017 reg_tck_enable SHALL be high for exactly one cycle when synchronised TCK is 1 and the previous value is 0; an internal tck_fall strobe SHALL be produced likewise on a 1-to-0 transition.
REQ-018 The 16-state IEEE 1149.1 FSM SHALL advance only in a cycle where reg_tck_enable=1, using the synchronised TMS from that same cycle.
REQ-019 FSM transitions, given as state: next state for TMS=0 / TMS=1:
- TLR: RTI / TLR
- RTI: RTI / SEL_DR
- SEL_DR: CAP_DR / SEL_IR
- SEL_IR: CAP_IR / TLR
- CAP_x: SHIFT_x / EXIT1_x
- SHIFT_x: SHIFT_x / EXIT1_x
- EXIT1_x: PAUSE_x / UPDATE_x
- PAUSE_x: PAUSE_x / EXIT2_x
- EXIT2_x: SHIFT_x / UPDATE_x
- UPDATE_x: RTI / SEL_DR
REQ-020 State codes SHALL be: TLR F, RTI C, SEL_DR 7, CAP_DR 6, SHIFT_DR 2, EXIT1_DR 1, PAUSE_DR 3, EXIT2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SHIFT_IR A, EXIT1_IR 9, PAUSE_IR B, EXIT2_IR 8, UPD_IR D.
REQ-021 The reg_test_logic_reset and capture/shift/update outputs SHALL be decoded combinationally from the state register, so the data registers act on the reg_tck_enable that leaves that state.
REQ-022 Five consecutive reg_tck_enable strobes with TMS=1 SHALL reach TLR from any state.
REQ-023 On tck_fall, reg_tdo SHALL load reg_tdo_from_dr, and reg_tdo_oe SHALL load 1 if the state is SHIFT_DR or SHIFT_IR, else 0.
REQ-024 A TCK glitch shorter than one internal_clk period SHALL produce either no strobe or a single strobe, never two within the same TCK half-period.
REQ-025 reg_digital_input SHALL be the synchronised TDI, so it is sampled in the same cycle as reg_tck_enable.

Reset
REQ-026 While reg_rst=1, independent of internal_clk: state = TLR, all synchroniser flops = 0, previous-TCK flop = 0, reg_tdo = 0, reg_tdo_oe = 0.
REQ-027 As a consequence of REQ-026, during reset reg_test_logic_reset=1, reg_tck_enable=0, all capture/shift/update outputs = 0, and reg_tap_state = 4'hF.
REQ-028 reg_rst asserted mid-shift SHALL abort the shift immediately; the first TCK rising edge after release SHALL be evaluated from TLR.

Structure
REQ-029 The state typedef (tap_state_e, 4-bit) and the SYNC_STAGES default SHALL live in a shared package, tap_pkg, that the data register block also imports.
REQ-030 Synchroniser plus edge detection SHALL be one sub-module, tck_edge_sync, instantiated once for TCK (providing the rise and fall strobes) with TMS/TDI carried alongside.
REQ-031 The FSM and TDO register SHALL reside in tap_controller; target size is 150-300 lines of RTL.

Verification
REQ-032 Reset pulse, then TCK toggled 8 times with TMS=0 -> exactly 8 reg_tck_enable strobes; state TLR then RTI; reg_tap_state = 4'hC.
REQ-033 From RTI, TMS sequence 1,0,0 then 4 edges with TMS=0 -> reg_capture_dr high for one TCK period, then reg_shift_dr held for 4 strobes; reg_tdo_oe=1 after the first tck_fall in SHIFT_DR.
REQ-034 From RTI, TMS sequence 1,1,0,0, shift 0101 LSB-first, then TMS 1,1 -> path CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR; reg_update_ir high for one TCK period; reg_digital_input matches TDI at each strobe.
REQ-035 From SHIFT_DR with 5 TMS=1 edges -> state TLR and reg_test_logic_reset=1 on the fifth strobe; also from PAUSE_IR -> TLR within 5 strobes.
REQ-036 Assert reg_rst in SHIFT_IR between TCK edges -> state immediately 4'hF, reg_shift_ir=0, reg_tdo_oe=0, with no internal_clk edge required.
REQ-037 Drive reg_tdo_from_dr with pattern 1,0,1,1 during SHIFT_DR -> reg_tdo follows it, each bit updating only on tck_fall.
